// File: rtl/icarus_pkg.sv
// Shared encodings for the ID/EX stage: ALU op codes, ID/EX state values and the
// control bundle that the pipeline register captures or replaces with a bubble.
package icarus_pkg;

    localparam logic [4:0] ALUOP_NOP = 5'b00001;
    localparam logic [4:0] ALUOP_MUL = 5'b01100;

    typedef enum logic {
        IDEX_RUN      = 1'b0,
        IDEX_MUL_WAIT = 1'b1
    } idex_state_t;

    typedef struct packed {
        logic [1:0] reg_dest;
        logic [1:0] mem_to_reg;
        logic [1:0] byte_sel;
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       jump;
        logic       jump_mux;
        logic [4:0] alu_op;
    } idex_ctrl_t;

    // A bubble has no side effects: nothing written, no memory access, no control transfer.
    localparam idex_ctrl_t CTRL_BUBBLE = '{
        reg_dest:   2'b00,
        mem_to_reg: 2'b00,
        byte_sel:   2'b00,
        reg_write:  1'b0,
        alu_src:    1'b0,
        mem_write:  1'b0,
        mem_read:   1'b0,
        branch:     1'b0,
        jump:       1'b0,
        jump_mux:   1'b0,
        alu_op:     ALUOP_NOP
    };

endpackage

// File: rtl/id_ex_hazard_detect.sv
// Load-use detector: the load sitting in EX writes a register that the
// instruction currently in ID reads, so ID must wait one cycle.
module id_ex_hazard_detect
    import icarus_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       load_use
);

    // $zero is never a real dependency.
    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with bubble insertion on flush/load-use and a
// multi-cycle multiply hold. Optional stall counter under IDEX_STALL_COUNT_EN.
module id_ex_stage_register
    import icarus_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int DATA_W      = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WriteEnable,
    input  logic              Flush,
    input  logic [1:0]        ID_RegDest,
    input  logic [1:0]        ID_MemToReg,
    input  logic [1:0]        ID_ByteSel,
    input  logic              ID_RegWrite,
    input  logic              ID_AluSrc,
    input  logic              ID_MemWrite,
    input  logic              ID_MemRead,
    input  logic              ID_Branch,
    input  logic              ID_Jump,
    input  logic              ID_JumpMux,
    input  logic [4:0]        ID_AluOp,
    input  logic [DATA_W-1:0] ID_PCPlus4,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_Immediate,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic [4:0]        ID_Rd,
    output logic [1:0]        EX_RegDest,
    output logic [1:0]        EX_MemToReg,
    output logic [1:0]        EX_ByteSel,
    output logic              EX_RegWrite,
    output logic              EX_AluSrc,
    output logic              EX_MemWrite,
    output logic              EX_MemRead,
    output logic              EX_Branch,
    output logic              EX_Jump,
    output logic              EX_JumpMux,
    output logic [4:0]        EX_AluOp,
    output logic [DATA_W-1:0] EX_PCPlus4,
    output logic [DATA_W-1:0] EX_ReadData1,
    output logic [DATA_W-1:0] EX_ReadData2,
    output logic [DATA_W-1:0] EX_Immediate,
    output logic [4:0]        EX_Rs,
    output logic [4:0]        EX_Rt,
    output logic [4:0]        EX_Rd,
    output logic              Stall
`ifdef IDEX_STALL_COUNT_EN
    ,
    output logic [31:0]       StallCount
`endif
);

    localparam bit         MUL_STALLS    = (MUL_LATENCY > 1);
    localparam logic [3:0] MUL_WAIT_INIT = 4'(MUL_LATENCY - 1);

    idex_ctrl_t  id_ctrl;
    idex_ctrl_t  ctrl_reg, ctrl_next;
    idex_state_t state_reg, state_next;
    logic [3:0]  mul_count_reg, mul_count_next;

    logic [DATA_W-1:0] pc_plus4_reg, pc_plus4_next;
    logic [DATA_W-1:0] read_data1_reg, read_data1_next;
    logic [DATA_W-1:0] read_data2_reg, read_data2_next;
    logic [DATA_W-1:0] immediate_reg, immediate_next;
    logic [4:0]        rs_reg, rs_next;
    logic [4:0]        rt_reg, rt_next;
    logic [4:0]        rd_reg, rd_next;

    logic load_use;
    logic load_bubble;
    logic load_id;

    assign id_ctrl = '{
        reg_dest:   ID_RegDest,
        mem_to_reg: ID_MemToReg,
        byte_sel:   ID_ByteSel,
        reg_write:  ID_RegWrite,
        alu_src:    ID_AluSrc,
        mem_write:  ID_MemWrite,
        mem_read:   ID_MemRead,
        branch:     ID_Branch,
        jump:       ID_Jump,
        jump_mux:   ID_JumpMux,
        alu_op:     ID_AluOp
    };

    id_ex_hazard_detect u_hazard (
        .ex_mem_read (ctrl_reg.mem_read),
        .ex_rt       (rt_reg),
        .id_rs       (ID_Rs),
        .id_rt       (ID_Rt),
        .load_use    (load_use)
    );

    always_comb begin
        state_next      = state_reg;
        mul_count_next  = mul_count_reg;
        ctrl_next       = ctrl_reg;
        pc_plus4_next   = pc_plus4_reg;
        read_data1_next = read_data1_reg;
        read_data2_next = read_data2_reg;
        immediate_next  = immediate_reg;
        rs_next         = rs_reg;
        rt_next         = rt_reg;
        rd_next         = rd_reg;
        load_bubble     = 1'b0;
        load_id         = 1'b0;

        case (state_reg)
            IDEX_RUN: begin
                if (Flush || load_use) begin
                    load_bubble = 1'b1;
                end else if (WriteEnable) begin
                    load_id = 1'b1;
                end
            end
            IDEX_MUL_WAIT: begin
                mul_count_next = mul_count_reg - 4'd1;
                // Upstream was frozen, so the leaving edge takes the waiting ID instruction as-is.
                if (mul_count_reg == 4'd1) begin
                    state_next = IDEX_RUN;
                    load_id    = 1'b1;
                end
            end
            default: begin
                state_next = IDEX_RUN;
            end
        endcase

        if (load_bubble || load_id) begin
            ctrl_next       = load_bubble ? CTRL_BUBBLE : id_ctrl;
            pc_plus4_next   = ID_PCPlus4;
            read_data1_next = ID_ReadData1;
            read_data2_next = ID_ReadData2;
            immediate_next  = ID_Immediate;
            rs_next         = ID_Rs;
            rt_next         = ID_Rt;
            rd_next         = ID_Rd;
        end

        if (load_id && MUL_STALLS && (ID_AluOp == ALUOP_MUL)) begin
            state_next     = IDEX_MUL_WAIT;
            mul_count_next = MUL_WAIT_INIT;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg      <= IDEX_RUN;
            mul_count_reg  <= 4'd0;
            ctrl_reg       <= CTRL_BUBBLE;
            pc_plus4_reg   <= '0;
            read_data1_reg <= '0;
            read_data2_reg <= '0;
            immediate_reg  <= '0;
            rs_reg         <= 5'd0;
            rt_reg         <= 5'd0;
            rd_reg         <= 5'd0;
        end else begin
            state_reg      <= state_next;
            mul_count_reg  <= mul_count_next;
            ctrl_reg       <= ctrl_next;
            pc_plus4_reg   <= pc_plus4_next;
            read_data1_reg <= read_data1_next;
            read_data2_reg <= read_data2_next;
            immediate_reg  <= immediate_next;
            rs_reg         <= rs_next;
            rt_reg         <= rt_next;
            rd_reg         <= rd_next;
        end
    end

    assign Stall = (state_reg == IDEX_MUL_WAIT) || ((state_reg == IDEX_RUN) && load_use);

    assign EX_RegDest   = ctrl_reg.reg_dest;
    assign EX_MemToReg  = ctrl_reg.mem_to_reg;
    assign EX_ByteSel   = ctrl_reg.byte_sel;
    assign EX_RegWrite  = ctrl_reg.reg_write;
    assign EX_AluSrc    = ctrl_reg.alu_src;
    assign EX_MemWrite  = ctrl_reg.mem_write;
    assign EX_MemRead   = ctrl_reg.mem_read;
    assign EX_Branch    = ctrl_reg.branch;
    assign EX_Jump      = ctrl_reg.jump;
    assign EX_JumpMux   = ctrl_reg.jump_mux;
    assign EX_AluOp     = ctrl_reg.alu_op;
    assign EX_PCPlus4   = pc_plus4_reg;
    assign EX_ReadData1 = read_data1_reg;
    assign EX_ReadData2 = read_data2_reg;
    assign EX_Immediate = immediate_reg;
    assign EX_Rs        = rs_reg;
    assign EX_Rt        = rt_reg;
    assign EX_Rd        = rd_reg;

`ifdef IDEX_STALL_COUNT_EN
    logic [31:0] stall_count_reg;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            stall_count_reg <= 32'd0;
        end else if (Stall && (stall_count_reg != 32'hFFFF_FFFF)) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign StallCount = stall_count_reg;
`endif

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Directed bench for the ID/EX register: vector table for capture/hold/flush/load-use,
// hand sequences for multiply hold, back-to-back multiply and reset during the hold.
module tb_id_ex_stage_register;

    typedef struct packed {
        logic [1:0]  reg_dest;
        logic [1:0]  mem_to_reg;
        logic [1:0]  byte_sel;
        logic        reg_write;
        logic        alu_src;
        logic        mem_write;
        logic        mem_read;
        logic        branch;
        logic        jump;
        logic        jump_mux;
        logic [4:0]  alu_op;
        logic [31:0] pc_plus4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } fields_t;

    typedef struct packed {
        logic    we;
        logic    flush;
        fields_t in_f;
        logic    pre_stall;
        fields_t exp_f;
    } vec_t;

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    logic    write_enable = 1'b0;
    logic    flush = 1'b0;
    fields_t id_f = '0;
    fields_t ex_f;
    logic    stall;
    int      checks = 0;
    int      errors = 0;
`ifdef IDEX_STALL_COUNT_EN
    logic [31:0] stall_count;
`endif

    always #5 clk = ~clk;

    id_ex_stage_register #(.MUL_LATENCY(4), .DATA_W(32)) dut (
        .Clock        (clk),
        .Reset        (rst),
        .WriteEnable  (write_enable),
        .Flush        (flush),
        .ID_RegDest   (id_f.reg_dest),
        .ID_MemToReg  (id_f.mem_to_reg),
        .ID_ByteSel   (id_f.byte_sel),
        .ID_RegWrite  (id_f.reg_write),
        .ID_AluSrc    (id_f.alu_src),
        .ID_MemWrite  (id_f.mem_write),
        .ID_MemRead   (id_f.mem_read),
        .ID_Branch    (id_f.branch),
        .ID_Jump      (id_f.jump),
        .ID_JumpMux   (id_f.jump_mux),
        .ID_AluOp     (id_f.alu_op),
        .ID_PCPlus4   (id_f.pc_plus4),
        .ID_ReadData1 (id_f.rd1),
        .ID_ReadData2 (id_f.rd2),
        .ID_Immediate (id_f.imm),
        .ID_Rs        (id_f.rs),
        .ID_Rt        (id_f.rt),
        .ID_Rd        (id_f.rd),
        .EX_RegDest   (ex_f.reg_dest),
        .EX_MemToReg  (ex_f.mem_to_reg),
        .EX_ByteSel   (ex_f.byte_sel),
        .EX_RegWrite  (ex_f.reg_write),
        .EX_AluSrc    (ex_f.alu_src),
        .EX_MemWrite  (ex_f.mem_write),
        .EX_MemRead   (ex_f.mem_read),
        .EX_Branch    (ex_f.branch),
        .EX_Jump      (ex_f.jump),
        .EX_JumpMux   (ex_f.jump_mux),
        .EX_AluOp     (ex_f.alu_op),
        .EX_PCPlus4   (ex_f.pc_plus4),
        .EX_ReadData1 (ex_f.rd1),
        .EX_ReadData2 (ex_f.rd2),
        .EX_Immediate (ex_f.imm),
        .EX_Rs        (ex_f.rs),
        .EX_Rt        (ex_f.rt),
        .EX_Rd        (ex_f.rd),
        .Stall        (stall)
`ifdef IDEX_STALL_COUNT_EN
        ,
        .StallCount   (stall_count)
`endif
    );

    function automatic fields_t ins(input logic [4:0] op, input logic rw, input logic as,
                                    input logic mr, input logic [1:0] rdst, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd,
                                    input logic [31:0] imm, input logic [31:0] pc);
        fields_t f;
        f           = '0;
        f.alu_op    = op;
        f.reg_write = rw;
        f.alu_src   = as;
        f.mem_read  = mr;
        f.mem_to_reg = mr ? 2'b01 : 2'b00;
        f.reg_dest  = rdst;
        f.rs        = rs;
        f.rt        = rt;
        f.rd        = rd;
        f.imm       = imm;
        f.pc_plus4  = pc;
        f.rd1       = pc ^ 32'hA5A5_0000;
        f.rd2       = imm + 32'h1000_0007;
        return f;
    endfunction

    function automatic fields_t bubble_of(input fields_t f);
        fields_t b;
        b            = f;
        b.reg_dest   = 2'b00;
        b.mem_to_reg = 2'b00;
        b.byte_sel   = 2'b00;
        b.reg_write  = 1'b0;
        b.alu_src    = 1'b0;
        b.mem_write  = 1'b0;
        b.mem_read   = 1'b0;
        b.branch     = 1'b0;
        b.jump       = 1'b0;
        b.jump_mux   = 1'b0;
        b.alu_op     = 5'b00001;
        return b;
    endfunction

    task automatic chk_fields(input string name, input fields_t exp);
        checks++;
        if (ex_f !== exp) begin
            errors++;
            $display("FAIL %s: EX actual %h required %h", name, ex_f, exp);
        end else begin
            $display("ok   %s: EX %h", name, ex_f);
        end
    endtask

    task automatic chk_stall(input string name, input logic exp);
        checks++;
        if (stall !== exp) begin
            errors++;
            $display("FAIL %s: Stall actual %b required %b", name, stall, exp);
        end else begin
            $display("ok   %s: Stall %b", name, stall);
        end
    endtask

`ifdef IDEX_STALL_COUNT_EN
    task automatic chk_count(input string name, input logic [31:0] exp);
        checks++;
        if (stall_count !== exp) begin
            errors++;
            $display("FAIL %s: StallCount actual %0d required %0d", name, stall_count, exp);
        end else begin
            $display("ok   %s: StallCount %0d", name, stall_count);
        end
    endtask
`endif

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    fields_t reset_f, addi, add1, xins, lw5, dep, lw0, addz, lw7, swd, mul, mul2;
    vec_t    vecs[16];

    initial begin
        reset_f = bubble_of('0);
        addi = ins(5'b00001, 1'b1, 1'b1, 1'b0, 2'b01, 5'd1, 5'd2, 5'd3, 32'h5, 32'h104);
        add1 = ins(5'b00010, 1'b1, 1'b0, 1'b0, 2'b01, 5'd6, 5'd7, 5'd8, 32'h10, 32'h108);
        xins = ins(5'b00011, 1'b1, 1'b0, 1'b0, 2'b10, 5'd9, 5'd10, 5'd11, 32'h20, 32'h10C);
        xins.branch = 1'b1;
        xins.byte_sel = 2'b11;
        lw5  = ins(5'b00010, 1'b1, 1'b1, 1'b1, 2'b00, 5'd4, 5'd5, 5'd0, 32'h8, 32'h110);
        dep  = ins(5'b00011, 1'b1, 1'b0, 1'b0, 2'b01, 5'd5, 5'd6, 5'd9, 32'h30, 32'h114);
        lw0  = ins(5'b00010, 1'b1, 1'b1, 1'b1, 2'b00, 5'd4, 5'd0, 5'd0, 32'hC, 32'h118);
        addz = ins(5'b00011, 1'b1, 1'b0, 1'b0, 2'b01, 5'd0, 5'd0, 5'd12, 32'h0, 32'h11C);
        lw7  = ins(5'b00010, 1'b1, 1'b1, 1'b1, 2'b00, 5'd3, 5'd7, 5'd0, 32'h4, 32'h120);
        swd  = ins(5'b00010, 1'b0, 1'b1, 1'b0, 2'b00, 5'd1, 5'd7, 5'd0, 32'h14, 32'h124);
        swd.mem_write = 1'b1;
        mul  = ins(5'b01100, 1'b1, 1'b0, 1'b0, 2'b01, 5'd1, 5'd2, 5'd13, 32'h0, 32'h128);
        mul2 = ins(5'b01100, 1'b1, 1'b0, 1'b0, 2'b01, 5'd3, 5'd4, 5'd14, 32'h0, 32'h12C);

        //            we    flush in    pre   expected
        vecs[0]  = '{1'b1, 1'b0, addi, 1'b0, addi};
        vecs[1]  = '{1'b0, 1'b0, add1, 1'b0, addi};
        vecs[2]  = '{1'b0, 1'b0, xins, 1'b0, addi};
        vecs[3]  = '{1'b0, 1'b0, dep,  1'b0, addi};
        vecs[4]  = '{1'b1, 1'b1, xins, 1'b0, bubble_of(xins)};
        vecs[5]  = '{1'b1, 1'b0, lw5,  1'b0, lw5};
        vecs[6]  = '{1'b1, 1'b0, dep,  1'b1, bubble_of(dep)};
        vecs[7]  = '{1'b1, 1'b0, dep,  1'b0, dep};
        vecs[8]  = '{1'b1, 1'b0, lw0,  1'b0, lw0};
        vecs[9]  = '{1'b1, 1'b0, addz, 1'b0, addz};
        vecs[10] = '{1'b1, 1'b0, lw7,  1'b0, lw7};
        vecs[11] = '{1'b1, 1'b0, swd,  1'b1, bubble_of(swd)};
        vecs[12] = '{1'b1, 1'b0, swd,  1'b0, swd};
        vecs[13] = '{1'b1, 1'b0, lw7,  1'b0, lw7};
        vecs[14] = '{1'b0, 1'b0, swd,  1'b1, bubble_of(swd)};
        vecs[15] = '{1'b1, 1'b0, addi, 1'b0, addi};

        // Asynchronous reset mid-cycle with random inputs, no edge needed
        id_f.pc_plus4 = $urandom;
        id_f.rd1      = $urandom;
        id_f.rd2      = $urandom;
        id_f.imm      = $urandom;
        id_f.alu_op   = 5'($urandom);
        id_f.rs       = 5'($urandom);
        id_f.rt       = 5'($urandom);
        id_f.mem_read = 1'b1;
        write_enable  = 1'($urandom);
        #2 rst = 1'b1;
        #1;
        chk_fields("reset_async", reset_f);
        chk_stall("reset_async", 1'b0);
        edge_step();
        rst = 1'b0;
        chk_fields("reset_held", reset_f);

        for (int i = 0; i < 16; i++) begin
            id_f         = vecs[i].in_f;
            write_enable = vecs[i].we;
            flush        = vecs[i].flush;
            #1;
            chk_stall($sformatf("vec%0d_pre", i), vecs[i].pre_stall);
            edge_step();
            chk_fields($sformatf("vec%0d_ex", i), vecs[i].exp_f);
        end

        // Multiply: 3 stall cycles, EX frozen, flush ignored, next captured on 4th edge
        id_f = mul;
        write_enable = 1'b1;
        #1 chk_stall("mul_pre", 1'b0);
        edge_step();
        chk_fields("mul_e1", mul);
        chk_stall("mul_e1", 1'b1);
        id_f = add1;
        flush = 1'b1;
        edge_step();
        chk_fields("mul_e2", mul);
        chk_stall("mul_e2", 1'b1);
        edge_step();
        chk_fields("mul_e3", mul);
        chk_stall("mul_e3", 1'b1);
        flush = 1'b0;
        edge_step();
        chk_fields("mul_e4", add1);
        chk_stall("mul_e4", 1'b0);

        // Back-to-back multiplies
        id_f = mul;
        edge_step();
        id_f = mul2;
        edge_step();
        edge_step();
        edge_step();
        chk_fields("mul2_captured", mul2);
        chk_stall("mul2_rewait", 1'b1);
        id_f = add1;
        edge_step();
        edge_step();
        chk_stall("mul2_last", 1'b1);
        edge_step();
        chk_fields("mul2_next", add1);
        chk_stall("mul2_done", 1'b0);

        // Reset during the multiply hold
        id_f = mul;
        edge_step();
        chk_stall("mulrst_wait", 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_stall("mulrst_async", 1'b0);
        chk_fields("mulrst_async", reset_f);
        edge_step();
        rst = 1'b0;
`ifdef IDEX_STALL_COUNT_EN
        chk_count("cnt_after_reset", 32'd0);
`endif
        id_f = addi;
        #1 chk_stall("mulrst_run", 1'b0);
        edge_step();
        chk_fields("mulrst_capture", addi);

        // Load-use (1 stall) then multiply (3 stalls)
        id_f = lw5;
        edge_step();
        id_f = dep;
        #1 chk_stall("lu_mul_pre", 1'b1);
        edge_step();
        id_f = mul;
        edge_step();
        chk_fields("lu_mul_captured", mul);
        id_f = add1;
        edge_step();
        edge_step();
        edge_step();
        chk_fields("lu_mul_next", add1);
        chk_stall("lu_mul_done", 1'b0);
`ifdef IDEX_STALL_COUNT_EN
        chk_count("cnt_lu_mul", 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
